// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, ALU/control types and memory depths shared by the MIPS core (MIPS_MULT_EN adds multiplier controls)
package mips_pkg;

    localparam int IMEM_DEPTH = 64;
    localparam int DMEM_DEPTH = 64;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI} alu_op_t;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_t;
    typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_HI, WB_LO} wb_t;

    typedef struct packed {
        logic    reg_write;
        dst_t    dst;
        logic    alu_imm;
        logic    imm_zext;
        alu_op_t alu_op;
        logic    mem_write;
        wb_t     wb;
        logic    beq;
        logic    bne;
        logic    jump;
        logic    jr;
`ifdef MIPS_MULT_EN
        logic    mult;
        logic    mult_signed;
`endif
    } ctrl_t;

endpackage

// File: rtl/mips_if.sv
// mips_if: instruction fetch bus between the core (master, drives PC) and the instruction ROM (slave)
interface mips_if;
    logic [31:0] pc;
    logic [31:0] instr;
    modport master (output pc, input instr);
    modport slave (input pc, output instr);
endinterface

// File: rtl/mips_core.sv
// mips_core: instruction decoder (controller) plus datapath instance dp
module mips_core
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    mips_if.master bus
);
    ctrl_t       ctrl;
    logic [5:0]  op, funct;
    logic [31:0] pc;

    assign op     = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign bus.pc = pc;

    // decode; anything unrecognised leaves every control low, i.e. a NOP
    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.dst = DST_RD;
                case (funct)
                    F_ADD, F_ADDU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD;  end
                    F_SUB, F_SUBU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB;  end
                    F_AND:         begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND;  end
                    F_OR:          begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;   end
                    F_SLT:         begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT;  end
                    F_SLTU:        begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLTU; end
                    F_JR:          ctrl.jr = 1'b1;
`ifdef MIPS_MULT_EN
                    F_MULT, F_MULTU: begin ctrl.mult = 1'b1; ctrl.mult_signed = (funct == F_MULT); end
                    F_MFHI:        begin ctrl.reg_write = 1'b1; ctrl.wb = WB_HI; end
                    F_MFLO:        begin ctrl.reg_write = 1'b1; ctrl.wb = WB_LO; end
`endif
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; ctrl.alu_op = ALU_ADD; end
            OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; ctrl.imm_zext = 1'b1; ctrl.alu_op = ALU_AND; end
            OP_ORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; ctrl.imm_zext = 1'b1; ctrl.alu_op = ALU_OR; end
            OP_LUI:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LUI; end
            OP_LW:   begin ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; ctrl.wb = WB_MEM; end
            OP_SW:   begin ctrl.mem_write = 1'b1; ctrl.alu_imm = 1'b1; end
            OP_BEQ:  ctrl.beq = 1'b1;
            OP_BNE:  ctrl.bne = 1'b1;
            OP_J:    ctrl.jump = 1'b1;
            OP_JAL:  begin ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; ctrl.dst = DST_RA; ctrl.wb = WB_PC4; end
            default: ;
        endcase
    end

    mips_datapath dp (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .instr (bus.instr[25:0]),
        .pc    (pc)
    );
endmodule

// File: rtl/mips_datapath.sv
// mips_datapath: PC, register file, ALU, data RAM and (with MIPS_MULT_EN) the HI/LO multiplier
module mips_datapath
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ctrl_t       ctrl,
    input  logic [25:0] instr,
    output logic [31:0] pc
);
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic [31:0] rd1, rd2, imm_ext, srcb, alu_y, wd, mem_rd, pc4, pc_next;
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic        taken;

    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm     = instr[15:0];
    assign imm_ext = ctrl.imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
    assign srcb    = ctrl.alu_imm ? imm_ext : rd2;
    assign wa      = (ctrl.dst == DST_RD) ? rd : (ctrl.dst == DST_RA) ? 5'd31 : rt;
    assign pc4     = pc + 32'd4;
    assign taken   = (ctrl.beq && rd1 == rd2) || (ctrl.bne && rd1 != rd2);
    assign pc_next = ctrl.jr ? rd1 : ctrl.jump ? {pc4[31:28], instr, 2'b00} : taken ? pc4 + {imm_ext[29:0], 2'b00} : pc4;
    assign mem_rd  = dmem[alu_y[7:2]];

    // writes are gated by reset so an edge seen while reset is low changes nothing
    mips_regfile gpr (
        .clk (clk),
        .we  (ctrl.reg_write && reset),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // ALU
    always_comb begin
        alu_y = rd1 + srcb;
        case (ctrl.alu_op)
            ALU_SUB:  alu_y = rd1 - srcb;
            ALU_AND:  alu_y = rd1 & srcb;
            ALU_OR:   alu_y = rd1 | srcb;
            ALU_SLT:  alu_y = {31'b0, $signed(rd1) < $signed(srcb)};
            ALU_SLTU: alu_y = {31'b0, rd1 < srcb};
            ALU_LUI:  alu_y = {imm, 16'h0};
            default:  ;
        endcase
    end

`ifdef MIPS_MULT_EN
    logic [31:0] hi, lo;
    logic [63:0] ma, mb, prod;

    // operands extended to 64 bits, so one truncated product serves both signed and unsigned
    assign ma   = {{32{ctrl.mult_signed & rd1[31]}}, rd1};
    assign mb   = {{32{ctrl.mult_signed & rd2[31]}}, rd2};
    assign prod = ma * mb;

    // HI/LO product registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {hi, lo} <= '0;
        else if (ctrl.mult) {hi, lo} <= prod;
    end
`endif

    // writeback source select
    always_comb begin
        wd = alu_y;
        case (ctrl.wb)
            WB_MEM:  wd = mem_rd;
            WB_PC4:  wd = pc4;
`ifdef MIPS_MULT_EN
            WB_HI:   wd = hi;
            WB_LO:   wd = lo;
`endif
            default: ;
        endcase
    end

    // program counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else pc <= pc_next;
    end

    // data RAM write port, not reset
    always_ff @(posedge clk) begin
        if (ctrl.mem_write && reset) dmem[alu_y[7:2]] <= rd2;
    end
endmodule

// File: rtl/mips_imem.sv
// mips_imem: 64-word instruction ROM, contents preloaded through the hierarchy; PC wraps modulo ROM depth
module mips_imem
    import mips_pkg::*;
(
    mips_if.slave bus
);
    logic [31:0] INSTRROM [0:IMEM_DEPTH-1];
    logic        unused_pc;

    assign bus.instr = INSTRROM[bus.pc[7:2]];
    assign unused_pc = &{1'b0, bus.pc[31:8], bus.pc[1:0]};
endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero, no reset
module mips_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];

    // write port; writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) registers[wa] <= wd;
    end
endmodule

// File: rtl/mips_processor.sv
// mips_processor: single-cycle MIPS-subset CPU top (ROM imem + core mips); define MIPS_MULT_EN for HI/LO multiply support
module mips_processor (
    input logic clk,
    input logic reset
);
    mips_if bus ();

    mips_imem imem (
        .bus (bus.slave)
    );

    mips_core mips (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );
endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed programs with fixed expectations, then random programs against an instruction-level reference model
module tb_mips_processor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_rom [64];
    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc, m_hi, m_lo;

    localparam logic [5:0] RFN [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h10, 6'h12};
    localparam logic [5:0] IOP [9]  = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};

    mips_processor dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] er(logic [5:0] f, logic [4:0] s, logic [4:0] t, logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] ei(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] ej(logic [5:0] op, logic [25:0] tg);
        return {op, tg};
    endfunction

    function automatic logic [31:0] gpr(int i);
        return dut.mips.dp.gpr.registers[i];
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // reference: execute one instruction at ISA level
    task automatic m_step();
        logic [31:0] ins, a, b, se, ze, npc, addr;
        logic [4:0]  s, t, d;
        ins  = m_rom[m_pc[7:2]];
        s    = ins[25:21];
        t    = ins[20:16];
        d    = ins[15:11];
        a    = m_rf[s];
        b    = m_rf[t];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'h0, ins[15:0]};
        addr = a + se;
        npc  = m_pc + 32'd4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: wr(d, a + b);
                6'h22, 6'h23: wr(d, a - b);
                6'h24: wr(d, a & b);
                6'h25: wr(d, a | b);
                6'h2a: wr(d, {31'b0, $signed(a) < $signed(b)});
                6'h2b: wr(d, {31'b0, a < b});
                6'h08: npc = a;
`ifdef MIPS_MULT_EN
                6'h18: {m_hi, m_lo} = longint'($signed(a)) * longint'($signed(b));
                6'h19: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
                6'h10: wr(d, m_hi);
                6'h12: wr(d, m_lo);
`endif
                default: ;
            endcase
            6'h08, 6'h09: wr(t, a + se);
            6'h0c: wr(t, a & ze);
            6'h0d: wr(t, a | ze);
            6'h0f: wr(t, {ins[15:0], 16'h0});
            6'h23: wr(t, m_mem[addr[7:2]]);
            6'h2b: m_mem[addr[7:2]] = b;
            6'h04: if (a == b) npc = npc + (se << 2);
            6'h05: if (a != b) npc = npc + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin wr(5'd31, npc); npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
        m_pc = npc;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [4:0] s, t, d;
        logic [5:0] op;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return er(RFN[$urandom_range(0, 11)], s, t, d);
            4, 5, 6: begin
                op = IOP[$urandom_range(0, 8)];
                return ei(op, s, t, (op == 6'h04 || op == 6'h05) ? 16'($signed(5'($urandom_range(0, 31)))) : 16'($urandom));
            end
            7: return ej($urandom_range(0, 1) ? 6'h02 : 6'h03, 26'($urandom_range(0, 63)));
            8: return er(6'h08, s, 5'd0, 5'd0);
            default: return $urandom;
        endcase
    endfunction

    // reset, load ROM/registers/RAM, release reset on a falling edge
    task automatic boot(input bit rnd);
        logic [31:0] v;
        reset = 1'b0;
        #1;
        check("reset_pc", dut.mips.dp.pc, 32'h0);
`ifdef MIPS_MULT_EN
        check("reset_hi", dut.mips.dp.hi, 32'h0);
        check("reset_lo", dut.mips.dp.lo, 32'h0);
`endif
        @(negedge clk);
        for (int i = 0; i < 64; i++) dut.imem.INSTRROM[i] = m_rom[i];
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'h0 : rnd ? $urandom : 32'hcafebabe;
            m_rf[i] = v;
            dut.mips.dp.gpr.registers[i] <= v;
        end
        for (int i = 0; i < 64; i++) begin
            v = rnd ? $urandom : 32'h0;
            m_mem[i] = v;
            dut.mips.dp.dmem[i] <= v;
        end
        m_pc = 0;
        m_hi = 0;
        m_lo = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            m_step();
        end
        @(negedge clk);
    endtask

    // pull reset low between edges, hold it across one edge, release
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1 check("mid_reset_pc", dut.mips.dp.pc, 32'h0);
        m_pc = 0;
        m_hi = 0;
        m_lo = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) m_rom[i] = 32'h0;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), gpr(i), m_rf[i]);
        for (int i = 0; i < 64; i++) check($sformatf("%s_m%0d", tag, i), dut.mips.dp.dmem[i], m_mem[i]);
        check({tag, "_pc"}, dut.mips.dp.pc, m_pc);
`ifdef MIPS_MULT_EN
        check({tag, "_hi"}, dut.mips.dp.hi, m_hi);
        check({tag, "_lo"}, dut.mips.dp.lo, m_lo);
`endif
    endtask

    initial begin
        // constants
        clear_rom();
        m_rom[0] = ei(6'h0f, 0, 1, 16'h1234);
        m_rom[1] = ei(6'h0d, 1, 1, 16'h5678);
        m_rom[2] = ei(6'h09, 0, 2, 16'hffff);
        boot(0);
        cycles(3);
        check("const_r1", gpr(1), 32'h12345678);
        check("const_r2", gpr(2), 32'hffffffff);
        check("const_r3", gpr(3), 32'hcafebabe);
        check("const_r31", gpr(31), 32'hcafebabe);
        check("const_pc", dut.mips.dp.pc, 32'd12);

        // fibonacci loop, plus a write to $0
        clear_rom();
        m_rom[0] = ei(6'h09, 0, 1, 16'h0);
        m_rom[1] = ei(6'h09, 0, 2, 16'h1);
        m_rom[2] = ei(6'h09, 0, 4, 16'h5);
        m_rom[3] = er(6'h21, 1, 2, 3);
        m_rom[4] = er(6'h21, 2, 0, 1);
        m_rom[5] = er(6'h21, 3, 0, 2);
        m_rom[6] = ei(6'h09, 4, 4, 16'hffff);
        m_rom[7] = ei(6'h05, 4, 0, 16'hfffb);
        m_rom[8] = ei(6'h09, 0, 0, 16'h5);
        m_rom[9] = ej(6'h02, 26'd9);
        boot(0);
        cycles(31);
        check("fib_r1", gpr(1), 32'd5);
        check("fib_r2", gpr(2), 32'd8);
        check("fib_r3", gpr(3), 32'd8);
        check("fib_r4", gpr(4), 32'd0);
        check("fib_r0", gpr(0), 32'd0);
        check("fib_pc", dut.mips.dp.pc, 32'd36);

        // jal / jr subroutine
        clear_rom();
        m_rom[0] = ei(6'h09, 0, 4, 16'h5);
        m_rom[1] = ei(6'h09, 0, 6, 16'h0);
        m_rom[2] = ej(6'h03, 26'd6);
        m_rom[3] = ei(6'h09, 6, 6, 16'h1);
        m_rom[4] = ej(6'h02, 26'd4);
        m_rom[6] = er(6'h21, 4, 4, 5);
        m_rom[7] = er(6'h08, 31, 0, 0);
        boot(0);
        cycles(10);
        check("call_r31", gpr(31), 32'd12);
        check("call_r5", gpr(5), 32'd10);
        check("call_r6", gpr(6), 32'd1);
        check("call_pc", dut.mips.dp.pc, 32'd16);

        // multiply
        clear_rom();
        m_rom[0] = ei(6'h09, 0, 1, 16'h7);
        m_rom[1] = ei(6'h09, 0, 2, 16'hfffd);
        m_rom[2] = er(6'h18, 1, 2, 0);
        m_rom[3] = er(6'h12, 0, 0, 3);
        m_rom[4] = er(6'h10, 0, 0, 4);
        m_rom[5] = ei(6'h09, 0, 5, 16'hffff);
        m_rom[6] = ei(6'h09, 0, 6, 16'h2);
        m_rom[7] = er(6'h19, 5, 6, 0);
        m_rom[8] = er(6'h12, 0, 0, 7);
        m_rom[9] = er(6'h10, 0, 0, 8);
        boot(0);
        cycles(10);
`ifdef MIPS_MULT_EN
        check("mul_lo", gpr(3), 32'hffffffeb);
        check("mul_hi", gpr(4), 32'hffffffff);
        check("mulu_lo", gpr(7), 32'hfffffffe);
        check("mulu_hi", gpr(8), 32'h00000001);
`else
        check("mul_nop_r3", gpr(3), 32'hcafebabe);
        check("mul_nop_r4", gpr(4), 32'hcafebabe);
        check("mul_nop_r7", gpr(7), 32'hcafebabe);
        check("mul_nop_r8", gpr(8), 32'hcafebabe);
`endif
        check("mul_pc", dut.mips.dp.pc, 32'd40);

        // sltu / slt / bne
        clear_rom();
        m_rom[0] = ei(6'h09, 0, 1, 16'h1);
        m_rom[1] = ei(6'h09, 0, 2, 16'hffff);
        m_rom[2] = er(6'h2b, 1, 2, 3);
        m_rom[3] = er(6'h2a, 1, 2, 4);
        m_rom[4] = ei(6'h05, 3, 0, 16'h1);
        m_rom[5] = ei(6'h09, 0, 5, 16'h9);
        m_rom[6] = ei(6'h09, 0, 6, 16'h7);
        boot(0);
        cycles(6);
        check("slt_r3", gpr(3), 32'd1);
        check("slt_r4", gpr(4), 32'd0);
        check("slt_skip_r5", gpr(5), 32'hcafebabe);
        check("slt_r6", gpr(6), 32'd7);
        check("slt_pc", dut.mips.dp.pc, 32'd28);

        // store/load and mid-run reset
        clear_rom();
        m_rom[0] = ei(6'h09, 7, 7, 16'h1);
        m_rom[1] = ei(6'h09, 0, 1, 16'hffb3);
        m_rom[2] = ei(6'h2b, 0, 1, 16'h4);
        m_rom[3] = ei(6'h23, 0, 5, 16'h4);
        boot(0);
        cycles(4);
        check("mem_r5", gpr(5), 32'hffffffb3);
        check("mem_r7", gpr(7), 32'hcafebabf);
        mid_reset();
        check("rst_hold_r7", gpr(7), 32'hcafebabf);
        check("rst_hold_r5", gpr(5), 32'hffffffb3);
        check("rst_hold_pc", dut.mips.dp.pc, 32'h0);
        cycles(1);
        check("rerun_r7", gpr(7), 32'hcafebac0);
        check("rerun_pc", dut.mips.dp.pc, 32'd4);

        // random programs against the reference model
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 64; i++) m_rom[i] = rnd_ins();
            boot(1);
            if (r % 2 == 1) begin
                cycles($urandom_range(10, 60));
                mid_reset();
            end
            cycles(80);
            compare_all($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
